program_loader_ctrl: RTL and testbench
======================================

PROGRAM_LOADER_CTRL -- requirements
Module: program_loader_ctrl

Interface
REQ-001 Parameter: ADDR_W, 4, RAM address width.
REQ-002 Parameter: DATA_W, 8, RAM word width.
REQ-003 Parameter: RUN_TIMEOUT, 255, maximum RUN cycles without HLT before watchdog error.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  request a new load session.
REQ-007 Port: ld_valid  in  1  loader word valid.
REQ-008 Port: ld_ready  out  1  controller accepts a loader word.
REQ-009 Port: ld_addr  in  ADDR_W  target RAM address.
REQ-010 Port: ld_data  in  DATA_W  word to store.
REQ-011 Port: ld_last  in  1  qualifies the final word of a session.
REQ-012 Port: ram_we  out  1  RAM program-mode write strobe (drives RAM input_mode).
REQ-013 Port: ram_addr  out  ADDR_W  RAM write address (drives input_address).
REQ-014 Port: ram_wdata  out  DATA_W  RAM write data (drives input_program).
REQ-015 Port: cpu_run_n  out  1  CPU reset, active-low; 0 holds CPU in reset.
REQ-016 Port: hlt  in  1  HLT from control sequencer.
REQ-017 Port: done  out  1  program halted normally.
REQ-018 Port: err  out  1  sticky session error (overflow or watchdog).
REQ-019 Port: word_count  out  ADDR_W+1  words accepted this session.
REQ-020 Port: checksum  out  DATA_W  mod-2^DATA_W sum of accepted words.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, FLUSH, RUN, HALT.
REQ-022 IDLE: cpu_run_n=0, ld_ready=0; start -> LOAD.
REQ-023 Entry to LOAD SHALL clear word_count, checksum, err and done.
REQ-024 LOAD: ld_ready=1; handshake = ld_valid & ld_ready; start ignored.
REQ-025 Accepted word SHALL appear on ram_addr/ram_wdata with ram_we=1 for exactly the next cycle (1-cycle latency); ram_we=0 otherwise.
REQ-026 Each accept SHALL increment word_count and add ld_data to checksum (wrap mod 256).
REQ-027 Accept when word_count = 2^ADDR_W SHALL not write, SHALL set err and go to IDLE.
REQ-028 Accept with ld_last=1 -> FLUSH (ld_ready=0, ram_we=1 for that word); FLUSH -> RUN next cycle.
REQ-029 cpu_run_n SHALL be 1 only in RUN, never before the last write completes.
REQ-030 RUN: cycle counter from 0; hlt=1 -> HALT with done=1; counter reaching RUN_TIMEOUT without hlt -> HALT with err=1, done=0.
REQ-031 HALT: cpu_run_n=0; done/err/word_count/checksum held; start -> LOAD.
REQ-032 start in RUN or FLUSH SHALL be ignored; hlt outside RUN ignored.
REQ-033 Duplicate ld_addr in a session SHALL be written again (last write wins) and counted.

Reset
REQ-034 reset=0 at a clock edge SHALL force IDLE, cpu_run_n=0, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, err=0, word_count=0, checksum=0, watchdog=0.
REQ-035 Reset mid-LOAD SHALL discard any pending write (ram_we=0 in the following cycle).

Structure
REQ-036 State enum and default widths SHALL live in shared package sap_ctrl_pkg.
REQ-037 Watchdog counter SHALL be sub-module run_watchdog (clear, enable, expire outputs).

Verification
REQ-038 Load 9h=01,Ah=08,0h=79,1h=A0,2h=00,3h=7A (last on 3h) -> six ram_we pulses, word_count=6, checksum=9Ch, cpu_run_n rises 2 cycles after last accept.
REQ-039 After load, assert hlt 5 cycles into RUN -> HALT, done=1, err=0, cpu_run_n=0.
REQ-040 17 words with no ld_last -> 16 writes, 17th not written, err=1, state IDLE.
REQ-041 RUN with hlt never asserted, RUN_TIMEOUT=10 -> HALT at cycle 10, err=1, done=0.
REQ-042 reset=0 on the cycle of an accept -> no ram_we next cycle, all outputs at reset values.
REQ-043 Toggle ld_valid with gaps, start pulsed during RUN -> writes only on handshake, start ignored, session completes normally.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the program loader controller: FSM state encoding,
// default widths and a counter-width helper.
package sap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_RUN_TIMEOUT = 255;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/program_loader_ctrl_run_watchdog.sv
// RUN-phase watchdog: counts enabled cycles from zero and flags expiry on the
// cycle in which the count reaches TIMEOUT.
module run_watchdog
  import sap_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_RUN_TIMEOUT,
  parameter int CNT_W   = cnt_width(DEF_RUN_TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             expire_s;

  // Next count: cleared outside RUN, advances each enabled cycle, freezes on expiry.
  always_comb begin
    count_d  = count_q;
    expire_s = enable_i && (count_q == CNT_W'(TIMEOUT - 1));
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = expire_s;

endmodule

// File: rtl/program_loader_ctrl.sv
// Program loader controller: streams loader words into program RAM, releases
// the CPU from reset once the image is written, and supervises the run phase.
module program_loader_ctrl
  import sap_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_run_n,
  input  logic              hlt,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int WC_W  = ADDR_W + 1;
  localparam int WD_W  = cnt_width(RUN_TIMEOUT);

  state_e            state_q, state_d;
  logic              ld_ready_q, cpu_run_n_q, ram_we_q, done_q, err_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, checksum_q;
  logic [WC_W-1:0]   word_count_q;

  logic accept_s, full_s, load_entry_s, wr_accept_s, ovf_accept_s;
  logic run_halt_s, run_expire_s, wd_clear_s, wd_enable_s, wd_expire_s;

  run_watchdog #(
    .TIMEOUT (RUN_TIMEOUT),
    .CNT_W   (WD_W)
  ) u_run_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (wd_clear_s),
    .enable_i (wd_enable_s),
    .expire_o (wd_expire_s)
  );

  // Session events and FSM next state.
  always_comb begin
    state_d      = state_q;
    accept_s     = ld_valid && ld_ready_q;
    full_s       = (word_count_q == (WC_W'(1) << ADDR_W));
    load_entry_s = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    wr_accept_s  = accept_s && !full_s;
    ovf_accept_s = accept_s && full_s;
    wd_enable_s  = (state_q == ST_RUN);
    wd_clear_s   = (state_q != ST_RUN);
    run_halt_s   = wd_enable_s && hlt;
    run_expire_s = wd_enable_s && !hlt && wd_expire_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ovf_accept_s) begin
          state_d = ST_IDLE;
        end else if (wr_accept_s && ld_last) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_halt_s || run_expire_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake, RAM write port and session status registers.
  // ld_ready and cpu_run_n are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ld_ready_q   <= 1'b0;
      cpu_run_n_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ld_ready_q  <= (state_d == ST_LOAD);
      cpu_run_n_q <= (state_d == ST_RUN);
      ram_we_q    <= 1'b0;
      if (load_entry_s) begin
        word_count_q <= '0;
        checksum_q   <= '0;
        err_q        <= 1'b0;
        done_q       <= 1'b0;
      end else if (wr_accept_s) begin
        ram_we_q     <= 1'b1;
        ram_addr_q   <= ld_addr;
        ram_wdata_q  <= ld_data;
        word_count_q <= word_count_q + WC_W'(1);
        checksum_q   <= checksum_q + ld_data;
      end else if (ovf_accept_s) begin
        err_q <= 1'b1;
      end else if (run_halt_s) begin
        done_q <= 1'b1;
      end else if (run_expire_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end
  end

  assign ld_ready   = ld_ready_q;
  assign cpu_run_n  = cpu_run_n_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Scoreboard bench: expected RAM writes are queued as words are sent and a
// negedge monitor matches every ram_we pulse; status is checked directly.
module tb_program_loader_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_run_n;
  logic              hlt = 1'b0;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  program_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_run_n(cpu_run_n), .hlt(hlt),
    .done(done), .err(err), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ram_write: unexpected write addr=%0h data=%0h", ram_addr, ram_wdata);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          failures++;
          $display("FAIL ram_write: got %0h/%0h expected %0h/%0h",
                   ram_addr, ram_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Offer one word, wait (bounded) for ld_ready, and return just after the accepting edge.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic last, input logic expect_wr);
    int n;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    n = 0;
    while (ld_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ld_ready=%0b expected 1", ld_ready);
    end
    if (expect_wr) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_cpu_run_n"}, 32'(cpu_run_n), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int w0;
    logic [ADDR_W-1:0] addrs [6];
    logic [DATA_W-1:0] datas [6];
    addrs = '{4'h9, 4'hA, 4'h0, 4'h1, 4'h2, 4'h3};
    datas = '{8'h01, 8'h08, 8'h79, 8'hA0, 8'h00, 8'h7A};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    // Valid offered while IDLE must not produce a write.
    @(negedge clk); ld_valid = 1'b1; ld_addr = 4'h7; ld_data = 8'hEE;
    repeat (2) @(negedge clk);
    chk("idle_ld_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;

    // Six-word load, then halt after five RUN cycles.
    w0 = writes;
    pulse_start();
    for (int i = 0; i < 6; i++) send(addrs[i], datas[i], (i == 5), 1'b1);
    @(negedge clk);
    chk("flush_cpu_run_n", 32'(cpu_run_n), 32'd0);
    chk("flush_ram_we", 32'(ram_we), 32'd1);
    chk("flush_ld_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("run_cpu_run_n", 32'(cpu_run_n), 32'd1);
    chk("load6_writes", 32'(writes - w0), 32'd6);
    chk("load6_word_count", 32'(word_count), 32'd6);
    chk("load6_checksum", 32'(checksum), 32'h9C);
    repeat (4) @(negedge clk);
    hlt = 1'b1;
    @(negedge clk); hlt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_err", 32'(err), 32'd0);
    chk("halt_cpu_run_n", 32'(cpu_run_n), 32'd0);
    repeat (2) @(negedge clk); hlt = 1'b1;
    @(negedge clk); hlt = 1'b0;
    chk("halt_hold_done", 32'(done), 32'd1);
    chk("halt_hold_word_count", 32'(word_count), 32'd6);
    chk("halt_hold_checksum", 32'(checksum), 32'h9C);

    // Overflow: 17 words without ld_last, only 16 written.
    w0 = writes;
    pulse_start();
    chk("load_entry_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < 17; i++) send(4'(i), 8'(i + 1), 1'b0, (i < 16));
    @(negedge clk);
    @(negedge clk);
    chk("ovf_writes", 32'(writes - w0), 32'd16);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_done", 32'(done), 32'd0);
    chk("ovf_idle_ld_ready", 32'(ld_ready), 32'd0);
    chk("ovf_cpu_run_n", 32'(cpu_run_n), 32'd0);
    chk("ovf_word_count", 32'(word_count), 32'd16);
    chk("ovf_checksum", 32'(checksum), 32'h88);

    // Watchdog: 10 RUN cycles without hlt.
    pulse_start();
    chk("load_entry_err_clr", 32'(err), 32'd0);
    send(4'h5, 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("wd_last_run_cycle", 32'(cpu_run_n), 32'd1);
    @(negedge clk);
    chk("wd_cpu_run_n", 32'(cpu_run_n), 32'd0);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_done", 32'(done), 32'd0);

    // Reset on the cycle of an accept discards the write.
    pulse_start();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 4'hC; ld_data = 8'h3C; reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("midload_reset");
    reset = 1'b1; ld_valid = 1'b0;

    // Gapped valid, duplicate address, start pulsed in FLUSH and RUN.
    w0 = writes;
    pulse_start();
    send(4'h2, 8'h11, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    send(4'h2, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    send(4'h4, 8'h33, 1'b1, 1'b1);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("run_start_ignored_cpu", 32'(cpu_run_n), 32'd1);
    chk("run_start_ignored_rdy", 32'(ld_ready), 32'd0);
    hlt = 1'b1;
    @(negedge clk); hlt = 1'b0;
    chk("gap_writes", 32'(writes - w0), 32'd3);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_err", 32'(err), 32'd0);
    chk("gap_word_count", 32'(word_count), 32'd3);
    chk("gap_checksum", 32'(checksum), 32'h66);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
